// File: rtl/chip_top_wrapper.sv
// JTAG TAP wrapper: 16-state controller, 5-bit IR, and UDR / IDCODE / BYPASS data registers.
// Capture and shift happen on rising TCK; update and TDO happen on falling TCK.
module chip_top_wrapper #(
    parameter int unsigned IR_WIDTH   = 5,
    parameter int unsigned UDR_WIDTH  = 18,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic TCK,
    input  logic TRST_N,
    input  logic TMS,
    input  logic TDI,
    output logic TDO
);

    localparam logic [IR_WIDTH-1:0] IrUser   = '0;
    localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(1);

    typedef enum logic [3:0] {
        StTlr, StRti,
        StSelDr, StCapDr, StShDr, StEx1Dr, StPauDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPauIr, StEx2Ir, StUpdIr
    } tap_state_e;

    tap_state_e           state_q;
    logic [IR_WIDTH-1:0]  ir_shift_q;
    logic [IR_WIDTH-1:0]  ir_q;
    logic [UDR_WIDTH-1:0] udr_shift_q;
    logic [UDR_WIDTH-1:0] udr_latch_q;
    logic [31:0]          id_shift_q;
    logic                 bypass_q;
    logic                 tdo_q;
    logic                 tdo_d;
    logic                 sel_user;
    logic                 sel_idcode;

    // Unlisted instruction codes fall through to BYPASS.
    assign sel_user   = (ir_q == IrUser);
    assign sel_idcode = (ir_q == IrIdcode);

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q     <= StTlr;
            ir_shift_q  <= '0;
            udr_shift_q <= '0;
            id_shift_q  <= '0;
            bypass_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StTlr:   state_q <= TMS ? StTlr   : StRti;
                StRti:   state_q <= TMS ? StSelDr : StRti;
                StSelDr: state_q <= TMS ? StSelIr : StCapDr;
                StCapDr: state_q <= TMS ? StEx1Dr : StShDr;
                StShDr:  state_q <= TMS ? StEx1Dr : StShDr;
                StEx1Dr: state_q <= TMS ? StUpdDr : StPauDr;
                StPauDr: state_q <= TMS ? StEx2Dr : StPauDr;
                StEx2Dr: state_q <= TMS ? StUpdDr : StShDr;
                StUpdDr: state_q <= TMS ? StSelDr : StRti;
                StSelIr: state_q <= TMS ? StTlr   : StCapIr;
                StCapIr: state_q <= TMS ? StEx1Ir : StShIr;
                StShIr:  state_q <= TMS ? StEx1Ir : StShIr;
                StEx1Ir: state_q <= TMS ? StUpdIr : StPauIr;
                StPauIr: state_q <= TMS ? StEx2Ir : StPauIr;
                StEx2Ir: state_q <= TMS ? StUpdIr : StShIr;
                StUpdIr: state_q <= TMS ? StSelDr : StRti;
                default: state_q <= StTlr;
            endcase

            if (state_q == StCapIr) begin
                ir_shift_q <= IrIdcode;
            end else if (state_q == StShIr) begin
                ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
            end

            if (state_q == StCapDr) begin
                if (sel_user) begin
                    udr_shift_q <= udr_latch_q;
                end else if (sel_idcode) begin
                    id_shift_q <= IDCODE_VAL;
                end else begin
                    bypass_q <= 1'b0;
                end
            end else if (state_q == StShDr) begin
                if (sel_user) begin
                    udr_shift_q <= {TDI, udr_shift_q[UDR_WIDTH-1:1]};
                end else if (sel_idcode) begin
                    id_shift_q <= {TDI, id_shift_q[31:1]};
                end else begin
                    bypass_q <= TDI;
                end
            end
        end
    end

    always_comb begin
        tdo_d = 1'b0;
        if (state_q == StShIr) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == StShDr) begin
            if (sel_user) begin
                tdo_d = udr_shift_q[0];
            end else if (sel_idcode) begin
                tdo_d = id_shift_q[0];
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_q        <= IrIdcode;
            udr_latch_q <= '0;
            tdo_q       <= 1'b0;
        end else begin
            if (state_q == StTlr) begin
                ir_q <= IrIdcode;
            end else if (state_q == StUpdIr) begin
                ir_q <= ir_shift_q;
            end
            if (state_q == StUpdDr && sel_user) begin
                udr_latch_q <= udr_shift_q;
            end
            tdo_q <= tdo_d;
        end
    end

    assign TDO = tdo_q;

endmodule

// File: tb/tb_chip_top_wrapper.sv
// Bench for chip_top_wrapper: table of IR/DR scans plus pause, mid-scan reset and TMS-reset sequences.
// Expected TDO bits are queued when a scan starts and popped as each bit appears.
module tb_chip_top_wrapper;

    localparam logic [31:0] IdcodeVal = 32'h1000_0001;
    localparam logic [31:0] PatP      = 32'h0002_52B6;
    localparam logic [31:0] PatQ      = 32'h0003_0F5A;
    localparam logic [31:0] PatR      = 32'h0002_A5C3;

    logic tck = 1'b0;
    logic trst_n;
    logic tms;
    logic tdi;
    logic tdo;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];

    typedef struct {
        string       name;
        logic [4:0]  ir;
        int          n;
        logic [31:0] din;
        logic [31:0] dexp;
    } vec_t;

    vec_t vecs[8];

    chip_top_wrapper #(
        .IR_WIDTH   (5),
        .UDR_WIDTH  (18),
        .IDCODE_VAL (IdcodeVal)
    ) dut (
        .TCK    (tck),
        .TRST_N (trst_n),
        .TMS    (tms),
        .TDI    (tdi),
        .TDO    (tdo)
    );

    always #5 tck = ~tck;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] e, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e[i]);
    endtask

    task automatic pop_check(input string name);
        logic e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %b expected <no queued bit>", name, tdo);
        end else begin
            e = exp_q.pop_front();
            check(name, tdo, e);
        end
    endtask

    // From Capture: step into Shift and check the first captured bit.
    task automatic enter_shift(input string name);
        tick(1'b0, 1'b0);
        pop_check($sformatf("%s bit0", name));
    endtask

    // In Shift: shift bits lo..hi, leaving through Exit1 on bit hi.
    task automatic shift_seg(input string name, input logic [31:0] din, input int lo,
                             input int hi);
        for (int i = lo; i <= hi; i++) begin
            tick(i == hi, din[i]);
            if (i < hi) pop_check($sformatf("%s bit%0d", name, i + 1));
            else check($sformatf("%s exit", name), tdo, 1'b0);
        end
    endtask

    // RTI -> IR scan -> RTI; every IR capture must read back 00001.
    task automatic ir_scan(input logic [4:0] code);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        push_exp(32'h1, 5);
        enter_shift($sformatf("ir%05b", code));
        shift_seg($sformatf("ir%05b", code), {27'b0, code}, 0, 4);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // RTI -> DR scan of n bits -> RTI.
    task automatic dr_scan(input string name, input logic [31:0] din, input logic [31:0] dexp,
                           input int n);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        push_exp(dexp, n);
        enter_shift(name);
        shift_seg(name, din, 0, n - 1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"idcode",   5'b00001, 32, 32'hDEAD_BEEF, IdcodeVal};
        vecs[1] = '{"bypass",   5'b11111, 4,  32'h0000_000D, 32'h0000_000A};
        vecs[2] = '{"udr_load", 5'b00000, 18, PatP,          32'h0};
        vecs[3] = '{"udr_read", 5'b00000, 18, 32'h0,         PatP};
        vecs[4] = '{"udr_q",    5'b00000, 18, PatQ,          32'h0};
        vecs[5] = '{"other_bp", 5'b10101, 6,  32'h0000_002D, 32'h0000_001A};
        vecs[6] = '{"udr_keep", 5'b00000, 18, 32'h0,         PatQ};
        vecs[7] = '{"idcode2",  5'b00001, 32, 32'h0,         IdcodeVal};

        trst_n = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        #2;
        check("reset tdo", tdo, 1'b0);
        #1 trst_n = 1'b1;
        repeat (5) tick(1'b1, 1'b0);
        check("tlr tdo", tdo, 1'b0);
        tick(1'b0, 1'b0);

        // Default instruction after reset must be IDCODE.
        dr_scan("reset_idcode", 32'h0, IdcodeVal, 32);

        for (int k = 0; k < 8; k++) begin
            ir_scan(vecs[k].ir);
            dr_scan(vecs[k].name, vecs[k].din, vecs[k].dexp, vecs[k].n);
        end

        // Split UDR scan through Pause: shift must resume without recapture.
        ir_scan(5'b00000);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        push_exp(32'h0, 18);
        enter_shift("pause");
        shift_seg("pause", PatR, 0, 8);
        tick(1'b0, 1'b0);
        check("pause pau1", tdo, 1'b0);
        tick(1'b0, 1'b1);
        check("pause pau2", tdo, 1'b0);
        tick(1'b1, 1'b0);
        check("pause ex2", tdo, 1'b0);
        tick(1'b0, 1'b0);
        pop_check("pause bit9");
        shift_seg("pause", PatR, 9, 17);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        dr_scan("pause_read", PatP, PatR, 18);

        // Latch now holds PatP; reset in mid-shift must clear it and restore IDCODE.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        push_exp(PatP, 18);
        enter_shift("mid_rst");
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            pop_check($sformatf("mid_rst bit%0d", i + 1));
        end
        trst_n = 1'b0;
        #1;
        check("mid_rst tdo", tdo, 1'b0);
        exp_q.delete();
        #1 trst_n = 1'b1;
        tick(1'b0, 1'b0);
        dr_scan("rst_idcode", 32'h0, IdcodeVal, 32);
        ir_scan(5'b00000);
        dr_scan("rst_udr", 32'h0, 32'h0, 18);

        // Five TMS=1 edges from Shift-DR must land in TLR and reload IDCODE.
        ir_scan(5'b11111);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        check("tms5 tdo", tdo, 1'b0);
        tick(1'b0, 1'b0);
        dr_scan("tms5_idcode", 32'h0, IdcodeVal, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
